// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use, taken-branch and data-memory stall handling.
// Define PIPE_HAZARD_WDOG_EN to build in the memory-wait watchdog (Wdog_Err).
module pipe_hazard_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  ID_Rs,
   input  logic [4:0]  ID_Rt,
   input  logic        IDtoEX_MemRead,
   input  logic [4:0]  IDtoEX_Rt,
   input  logic        EX_BranchTaken,
   input  logic        MEM_MemReq,
   input  logic        MEM_MemReady,
   output logic        PC_En,
   output logic        IFtoID_En,
   output logic        IDtoEX_En,
   output logic        EXtoMEM_En,
   output logic        MEMtoWB_En,
   output logic        IFtoID_Flush,
   output logic        IDtoEX_Flush,
   output logic        MEMtoWB_Flush,
   output logic [15:0] Stall_Cycles,
   output logic        Wdog_Err
);

   typedef enum logic [1:0] {INIT, RUN, MWAIT} state_t;

   state_t state, state_nxt;
   logic   init_cnt;
   logic   load_use;
   logic   mem_stall;
   logic   mem_hold;
   logic   wdog_hit;

   assign load_use = IDtoEX_MemRead && (IDtoEX_Rt != 5'd0) &&
                     ((IDtoEX_Rt == ID_Rs) || (IDtoEX_Rt == ID_Rt));

`ifdef PIPE_HAZARD_WDOG_EN
   logic [7:0] wdog_cnt;
   logic       wdog_err;

   // Once the watchdog has fired, memory stalls are ignored until reset.
   assign mem_stall = MEM_MemReq && !MEM_MemReady && !wdog_err;
   // wdog_cnt counts completed MWAIT cycles, so 254 marks the 255th one.
   assign wdog_hit  = (state == MWAIT) && !MEM_MemReady && (wdog_cnt == 8'd254);
   assign Wdog_Err  = wdog_err;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wdog_cnt <= '0;
         wdog_err <= 1'b0;
      end else begin
         if (state == RUN && mem_stall)
            wdog_cnt <= '0;
         else if (state == MWAIT)
            wdog_cnt <= wdog_cnt + 8'd1;
         if (wdog_hit)
            wdog_err <= 1'b1;
      end
   end
`else
   assign mem_stall = MEM_MemReq && !MEM_MemReady;
   assign wdog_hit  = 1'b0;
   assign Wdog_Err  = 1'b0;
`endif

   assign mem_hold = (state == MWAIT) ? !MEM_MemReady : mem_stall;

   always_comb begin
      state_nxt     = state;
      PC_En         = 1'b1;
      IFtoID_En     = 1'b1;
      IDtoEX_En     = 1'b1;
      EXtoMEM_En    = 1'b1;
      MEMtoWB_En    = 1'b1;
      IFtoID_Flush  = 1'b0;
      IDtoEX_Flush  = 1'b0;
      MEMtoWB_Flush = 1'b0;
      case (state)
         INIT: begin
            PC_En         = 1'b0;
            IFtoID_En     = 1'b0;
            IDtoEX_En     = 1'b0;
            EXtoMEM_En    = 1'b0;
            MEMtoWB_En    = 1'b0;
            IFtoID_Flush  = 1'b1;
            IDtoEX_Flush  = 1'b1;
            MEMtoWB_Flush = 1'b1;
            if (init_cnt)
               state_nxt = RUN;
         end
         RUN, MWAIT: begin
            if (mem_hold) begin
               PC_En         = 1'b0;
               IFtoID_En     = 1'b0;
               IDtoEX_En     = 1'b0;
               EXtoMEM_En    = 1'b0;
               MEMtoWB_En    = 1'b0;
               MEMtoWB_Flush = 1'b1;
               if (state == RUN)
                  state_nxt = MWAIT;
               else if (wdog_hit)
                  state_nxt = RUN;
            end else begin
               state_nxt = RUN;
               if (EX_BranchTaken) begin
                  IFtoID_Flush = 1'b1;
                  IDtoEX_Flush = 1'b1;
               end else if (load_use) begin
                  PC_En        = 1'b0;
                  IFtoID_En    = 1'b0;
                  IDtoEX_Flush = 1'b1;
               end
            end
         end
         default: state_nxt = INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= INIT;
         init_cnt     <= 1'b0;
         Stall_Cycles <= '0;
      end else begin
         state    <= state_nxt;
         init_cnt <= (state == INIT);
         if (state != INIT && !PC_En && Stall_Cycles != 16'hFFFF)
            Stall_Cycles <= Stall_Cycles + 16'd1;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomised and directed bench for pipe_hazard_ctrl against a cycle-level behavioural model.
// Honours PIPE_HAZARD_WDOG_EN to match the watchdog build of the design.
module tb_pipe_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [4:0]  ID_Rs = '0, ID_Rt = '0, IDtoEX_Rt = '0;
   logic        IDtoEX_MemRead = 1'b0, EX_BranchTaken = 1'b0;
   logic        MEM_MemReq = 1'b0, MEM_MemReady = 1'b0;
   logic        PC_En, IFtoID_En, IDtoEX_En, EXtoMEM_En, MEMtoWB_En;
   logic        IFtoID_Flush, IDtoEX_Flush, MEMtoWB_Flush;
   logic [15:0] Stall_Cycles;
   logic        Wdog_Err;

   int unsigned errors = 0;
   int unsigned checks = 0;

   // model state: INIT cycles remaining, waiting on memory, MWAIT cycles elapsed
   int          m_init_left;
   bit          m_waiting;
   int          m_wait_cycles;
   bit          m_err;
   int          m_stalls;

   pipe_hazard_ctrl dut (
      .clk(clk), .rst(rst),
      .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
      .IDtoEX_MemRead(IDtoEX_MemRead), .IDtoEX_Rt(IDtoEX_Rt),
      .EX_BranchTaken(EX_BranchTaken),
      .MEM_MemReq(MEM_MemReq), .MEM_MemReady(MEM_MemReady),
      .PC_En(PC_En), .IFtoID_En(IFtoID_En), .IDtoEX_En(IDtoEX_En),
      .EXtoMEM_En(EXtoMEM_En), .MEMtoWB_En(MEMtoWB_En),
      .IFtoID_Flush(IFtoID_Flush), .IDtoEX_Flush(IDtoEX_Flush),
      .MEMtoWB_Flush(MEMtoWB_Flush),
      .Stall_Cycles(Stall_Cycles), .Wdog_Err(Wdog_Err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // {PC, IFID, IDEX, EXMEM, MEMWB enables, IFID, IDEX, MEMWB flushes}
   function automatic logic [7:0] ctl_vec();
      return {PC_En, IFtoID_En, IDtoEX_En, EXtoMEM_En, MEMtoWB_En,
              IFtoID_Flush, IDtoEX_Flush, MEMtoWB_Flush};
   endfunction

   localparam logic [7:0] CTL_INIT   = 8'b00000_111;
   localparam logic [7:0] CTL_RUN    = 8'b11111_000;
   localparam logic [7:0] CTL_MEM    = 8'b00000_001;
   localparam logic [7:0] CTL_BRANCH = 8'b11111_110;
   localparam logic [7:0] CTL_LU     = 8'b00111_010;

   function automatic bit wdog_built();
`ifdef PIPE_HAZARD_WDOG_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   task automatic do_reset();
      rst = 1'b0;
      #1;
      m_init_left = 2; m_waiting = 0; m_wait_cycles = 0; m_err = 0; m_stalls = 0;
      check("rst_ctl", {24'd0, ctl_vec()}, {24'd0, CTL_INIT});
      check("rst_stall", {16'd0, Stall_Cycles}, 32'd0);
      check("rst_wdog", {31'd0, Wdog_Err}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // One clock cycle: drive, check mid-cycle, advance the model across the edge.
   task automatic cycle(input logic [4:0] rs, input logic [4:0] rt, input logic mr,
                        input logic [4:0] exrt, input logic br, input logic req,
                        input logic rdy);
      logic [7:0] exp;
      bit lu, mstall, hold;
      ID_Rs = rs; ID_Rt = rt; IDtoEX_MemRead = mr; IDtoEX_Rt = exrt;
      EX_BranchTaken = br; MEM_MemReq = req; MEM_MemReady = rdy;
      #3;
      lu     = mr && exrt != 0 && (exrt == rs || exrt == rt);
      mstall = req && !rdy && !m_err;
      hold   = m_waiting ? !rdy : mstall;
      if (m_init_left > 0) exp = CTL_INIT;
      else if (hold)       exp = CTL_MEM;
      else if (br)         exp = CTL_BRANCH;
      else if (lu)         exp = CTL_LU;
      else                 exp = CTL_RUN;
      check("ctl", {24'd0, ctl_vec()}, {24'd0, exp});
      check("stall_cnt", {16'd0, Stall_Cycles}, m_stalls);
      check("wdog", {31'd0, Wdog_Err}, {31'd0, m_err});
      @(posedge clk);
      if (m_init_left > 0) begin
         m_init_left--;
      end else begin
         if (!exp[7] && m_stalls < 65535) m_stalls++;
         if (!m_waiting) begin
            if (mstall) begin
               m_waiting = 1; m_wait_cycles = 0;
            end
         end else if (rdy) begin
            m_waiting = 0;
         end else begin
            m_wait_cycles++;
            if (wdog_built() && m_wait_cycles == 255) begin
               m_err = 1; m_waiting = 0;
            end
         end
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      @(posedge clk);
      #1;
      do_reset();
      idle(4);                                             // 2 INIT + 2 RUN
      check("run_stall0", {16'd0, Stall_Cycles}, 32'd0);

      cycle(5'd5, 5'd7, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);     // load-use on Rs
      idle(1);
      check("lu_count", {16'd0, Stall_Cycles}, 32'd1);
      cycle(5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);     // Rt=0 never hazards
      cycle(5'd3, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1);     // load-use on Rt
      cycle(5'd5, 5'd7, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1);     // branch beats load-use
      idle(1);
      check("br_count", {16'd0, Stall_Cycles}, 32'd2);

      for (int i = 0; i < 3; i++) cycle(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      cycle(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);     // ready: back to RUN
      idle(1);
      check("mem_count", {16'd0, Stall_Cycles}, 32'd5);

      for (int i = 0; i < 2; i++) cycle(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      do_reset();                                          // mid-MWAIT reset
      idle(3);

      for (int i = 0; i < 3000; i++)
         cycle(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 99) < 15), 1'($urandom_range(0, 99) < 30),
               1'($urandom_range(0, 99) < 60));

      do_reset();
      idle(2);
      for (int i = 0; i < 300; i++) cycle(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      check("wdog_final", {31'd0, Wdog_Err}, {31'd0, wdog_built()});
      check("wdog_stalls", {16'd0, Stall_Cycles}, wdog_built() ? 32'd256 : 32'd300);
      for (int i = 0; i < 20; i++)
         cycle(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have ports ID_Rs and ID_Rt, input, 5 each: source registers of the instruction in ID.
REQ-004 SHALL have ports IDtoEX_MemRead (input, 1) and IDtoEX_Rt (input, 5): load flag and destination of the instruction in EX.
REQ-005 SHALL have port EX_BranchTaken, input, 1: branch resolved taken in EX.
REQ-006 SHALL have ports MEM_MemReq and MEM_MemReady, input, 1 each: MEM-stage data access request and data-memory completion.
REQ-007 SHALL have outputs PC_En, IFtoID_En, IDtoEX_En, EXtoMEM_En, MEMtoWB_En, 1 each: pipeline register load enables.
REQ-008 SHALL have outputs IFtoID_Flush, IDtoEX_Flush, MEMtoWB_Flush, 1 each: insert bubble (control fields zeroed) into that register.
REQ-009 SHALL have output Stall_Cycles, 16: saturating count of stalled cycles.
REQ-010 SHALL have output Wdog_Err, 1: sticky memory-timeout flag.

Function
REQ-011 SHALL implement states INIT, RUN, MWAIT in a registered state machine; all enable/flush outputs are combinational functions of state and inputs.
REQ-012 INIT SHALL last exactly 2 cycles after rst deasserts: all enables 0, all flushes 1; then RUN.
REQ-013 Load-use hazard := IDtoEX_MemRead & IDtoEX_Rt!=0 & (IDtoEX_Rt==ID_Rs | IDtoEX_Rt==ID_Rt).
REQ-014 Memory stall := MEM_MemReq & !MEM_MemReady.
REQ-015 RUN defaults: all enables 1, all flushes 0.
REQ-016 RUN with memory stall SHALL drive all enables 0, MEMtoWB_Flush 1, other flushes 0, and next state MWAIT; this takes priority over branch and load-use.
REQ-017 RUN with EX_BranchTaken and no memory stall SHALL drive IFtoID_Flush=1, IDtoEX_Flush=1, enables 1; branch overrides a simultaneous load-use.
REQ-018 RUN with load-use only SHALL drive PC_En=0, IFtoID_En=0, IDtoEX_Flush=1, others default; single-cycle penalty.
REQ-019 MWAIT SHALL hold REQ-016 outputs while MEM_MemReady=0; in the cycle MEM_MemReady=1 it SHALL apply RUN rules (REQ-015..018 without memory stall) and return to RUN.
REQ-020 Stall_Cycles SHALL increment by 1 every RUN/MWAIT cycle where PC_En=0, saturating at 16'hFFFF; INIT cycles not counted.

Reset
REQ-021 rst=0 SHALL immediately force state INIT (counter 0), Stall_Cycles=0, Wdog_Err=0, outputs per REQ-012, including mid-MWAIT.
REQ-022 INIT counter SHALL start only after rst deasserts.

Configuration
REQ-023 Macro PIPE_HAZARD_WDOG_EN SHALL compile in a memory watchdog.
REQ-024 With PIPE_HAZARD_WDOG_EN: 8-bit counter cleared on MWAIT entry, incremented each MWAIT cycle; when 255 MWAIT cycles elapse without MEM_MemReady, Wdog_Err SHALL set (sticky until reset) and next state RUN, abandoning the stall; afterwards memory stalls are ignored while Wdog_Err=1.
REQ-025 Without PIPE_HAZARD_WDOG_EN: no counter, Wdog_Err tied 0, MWAIT waits indefinitely; port list unchanged.

Verification
REQ-026 Release rst at cycle 0 -> flushes 1, enables 0 for cycles 0-1; RUN defaults from cycle 2; Stall_Cycles=0.
REQ-027 RUN, IDtoEX_MemRead=1, IDtoEX_Rt=5, ID_Rs=5 -> PC_En=0, IFtoID_En=0, IDtoEX_Flush=1 for one cycle; Stall_Cycles=1; same with IDtoEX_Rt=0 -> no stall.
REQ-028 EX_BranchTaken=1 together with load-use -> IFtoID_Flush=1, IDtoEX_Flush=1, PC_En=1, no stall count.
REQ-029 MEM_MemReq=1, MEM_MemReady low 3 cycles then high -> 3 cycles all enables 0 and MEMtoWB_Flush=1, RUN on 4th, Stall_Cycles=3; rst pulse during wait -> INIT immediately.
REQ-030 With PIPE_HAZARD_WDOG_EN, MEM_MemReady held 0 -> Wdog_Err=1 after 256 stalled cycles, enables return to 1; without macro Wdog_Err stays 0 and stall persists.
